// File: rtl/fifo_rd_pkg.sv
// Shared types and default widths for the FIFO stream reader.
// No logic; state encoding and parameter defaults only.
// Imported by fifo_stream_reader and stream_skid2.
package fifo_rd_pkg;

    localparam int DEF_DW    = 32;
    localparam int DEF_LEN_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

endpackage

// File: rtl/stream_skid2.sv
// Two-entry output buffer with a registered head word.
// Latency: a pushed word drives out_data/out_valid from the push edge onward.
// Backpressure: head holds while out_ready=0; the caller must not push when count=2 unless the head transfers.
module stream_skid2
    import fifo_rd_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    output logic [1:0]    count,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready
);

    logic [DW-1:0] tail;
    logic          xfer;

    assign xfer = out_valid && out_ready;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            count     <= 2'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
            tail      <= '0;
        end else begin
            case (count)
                2'd0: begin
                    if (push) begin
                        out_data  <= push_data;
                        out_valid <= 1'b1;
                        count     <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && !xfer) begin
                        tail  <= push_data;
                        count <= 2'd2;
                    end else if (push && xfer) begin
                        out_data <= push_data;
                    end else if (xfer) begin
                        out_valid <= 1'b0;
                        count     <= 2'd0;
                    end
                end
                default: begin
                    // Head advances to the tail; a concurrent push refills the tail.
                    if (xfer) begin
                        out_data <= tail;
                        if (push) begin
                            tail <= push_data;
                        end else begin
                            count <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// Reads a burst of burst_len words from a FIFO into a valid/ready stream; optional stall counter under FIFO_READER_STALL_CNT_EN.
// Latency: a word popped at edge N is presented on out_data from edge N; one word per cycle when unstalled.
// Backpressure: pops stop while the 2-entry buffer is full or the FIFO is empty; out_data holds while out_ready=0.
module fifo_stream_reader
    import fifo_rd_pkg::*;
#(
    parameter int LEN_W = DEF_LEN_W,
    parameter int DW    = DEF_DW
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic [LEN_W-1:0] burst_len,
    output logic             busy,
    output logic             done,
    output logic             fifo_pop,
    input  logic             fifo_is_empty,
    input  logic [DW-1:0]    fifo_dat_out,
    output logic             out_valid,
    output logic [DW-1:0]    out_data,
    input  logic             out_ready
`ifdef FIFO_READER_STALL_CNT_EN
    ,
    output logic [31:0]      stall_cnt
`endif
);

    rd_state_t        state;
    logic [LEN_W-1:0] remaining;
    logic [1:0]       count;
    logic             last_xfer;

    assign fifo_pop  = (state == READ) && (remaining != '0) && !fifo_is_empty && (count < 2'd2);
    assign busy      = (state != IDLE);
    // Nothing is pushed in DRAIN, so a transfer with one word left empties the buffer.
    assign last_xfer = out_valid && out_ready && (count == 2'd1);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            remaining <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (burst_len != '0) begin
                            remaining <= burst_len;
                            state     <= READ;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (fifo_pop) begin
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if ((count == 2'd0) || last_xfer) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FIFO_READER_STALL_CNT_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            stall_cnt <= '0;
        end else if ((state == IDLE) && start) begin
            stall_cnt <= '0;
        end else if ((state == READ) && fifo_is_empty && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

    stream_skid2 #(
        .DW(DW)
    ) u_skid (
        .clk       (clk),
        .nrst      (nrst),
        .push      (fifo_pop),
        .push_data (fifo_dat_out),
        .count     (count),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: directed bursts plus randomized traffic against a queue-based reference model.
module tb_fifo_stream_reader;

    logic        clk = 1'b0;
    logic        nrst;
    logic        start;
    logic [15:0] burst_len;
    logic        busy;
    logic        done;
    logic        fifo_pop;
    logic        fifo_is_empty;
    logic [31:0] fifo_dat_out;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
`ifdef FIFO_READER_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    fifo_stream_reader dut (
        .clk           (clk),
        .nrst          (nrst),
        .start         (start),
        .burst_len     (burst_len),
        .busy          (busy),
        .done          (done),
        .fifo_pop      (fifo_pop),
        .fifo_is_empty (fifo_is_empty),
        .fifo_dat_out  (fifo_dat_out),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_ready     (out_ready)
`ifdef FIFO_READER_STALL_CNT_EN
        ,
        .stall_cnt     (stall_cnt)
`endif
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Source FIFO contents and reference model state
    logic [31:0] fifo_q[$];
    logic [31:0] m_buf[$];
    logic [31:0] delivered[$];
    bit          m_busy;
    bit          m_done;
    int          m_rem;
    int          m_stall;
    int          n_pops, n_done, cyc, first_pop, last_pop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        fifo_is_empty = (fifo_q.size() == 0);
        fifo_dat_out  = fifo_is_empty ? 32'h0 : fifo_q[0];
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_done  = 1'b0;
        m_rem   = 0;
        m_stall = 0;
        m_buf.delete();
    endtask

    task automatic clear_stats();
        n_pops    = 0;
        n_done    = 0;
        first_pop = -1;
        last_pop  = -1;
        delivered.delete();
    endtask

    // One clock: check outputs at the negedge, advance the model, let the FIFO react after the posedge.
    task automatic step();
        bit exp_pop, exp_valid, pop_now;
        @(negedge clk);
        exp_pop   = m_busy && (m_rem > 0) && (fifo_q.size() > 0) && (m_buf.size() < 2);
        exp_valid = (m_buf.size() > 0);
        chk("fifo_pop", 32'(fifo_pop), 32'(exp_pop));
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        if (exp_valid) chk("out_data", out_data, m_buf[0]);
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
`ifdef FIFO_READER_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, 32'(m_stall));
`endif
        pop_now = fifo_pop;
        if (fifo_pop) begin
            n_pops++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
        end
        if (done) n_done++;
        if (out_valid && out_ready) delivered.push_back(out_data);

        m_done = 1'b0;
        if (!m_busy && start) begin
            m_stall = 0;
            if (burst_len != 16'd0) begin
                m_busy = 1'b1;
                m_rem  = int'(burst_len);
            end else begin
                m_done = 1'b1;
            end
        end else if (m_busy && (m_rem > 0) && (fifo_q.size() == 0)) begin
            m_stall++;
        end
        if (exp_valid && out_ready) void'(m_buf.pop_front());
        if (exp_pop) begin
            m_buf.push_back(fifo_q[0]);
            m_rem--;
        end
        if (m_busy && (m_rem == 0) && (m_buf.size() == 0)) begin
            m_busy = 1'b0;
            m_done = 1'b1;
        end

        @(posedge clk);
        #1;
        cyc++;
        if (pop_now && (fifo_q.size() > 0)) void'(fifo_q.pop_front());
        refresh();
    endtask

    task automatic run_idle(input int budget, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (!m_busy && !m_done) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_timeout"}, 32'(ok), 32'd1);
    endtask

    task automatic kick(input int len);
        start     = 1'b1;
        burst_len = 16'(len);
        step();
        start     = 1'b0;
    endtask

    task automatic chk_seq(input string tag, input logic [31:0] base, input int n);
        chk({tag, "_count"}, 32'(delivered.size()), 32'(n));
        for (int i = 0; i < n && i < delivered.size(); i++)
            chk({tag, "_word"}, delivered[i], base + 32'(i));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rexp[$];
        int          len, pushed;
        bit          ok;

        nrst = 1'b0; start = 1'b0; burst_len = '0; out_ready = 1'b0;
        cyc = 0;
        refresh();
        model_reset();
        clear_stats();
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fifo_pop", 32'(fifo_pop), 32'd0);
`ifdef FIFO_READER_STALL_CNT_EN
        chk("rst_stall_cnt", stall_cnt, 32'd0);
`endif
        step();
        step();
        nrst = 1'b1;
        step();

        // Four prefilled words streamed back to back
        for (int i = 0; i < 4; i++) fifo_q.push_back(32'h10 + 32'(i));
        refresh();
        out_ready = 1'b1;
        clear_stats();
        kick(4);
        run_idle(50, "b4");
        chk("b4_pops", 32'(n_pops), 32'd4);
        chk("b4_pop_span", 32'(last_pop - first_pop), 32'd3);
        chk_seq("b4", 32'h10, 4);
        chk("b4_done", 32'(n_done), 32'd1);

        // Downstream stall fills the buffer with two words then holds
        for (int i = 0; i < 3; i++) fifo_q.push_back(32'h20 + 32'(i));
        refresh();
        out_ready = 1'b0;
        kick(3);
        clear_stats();
        for (int i = 0; i < 5; i++) step();
        chk("stall_pops", 32'(n_pops), 32'd2);
        chk("stall_hold", out_data, 32'h20);
        out_ready = 1'b1;
        run_idle(50, "stall");
        chk("stall_total_pops", 32'(n_pops), 32'd3);
        chk_seq("stall", 32'h20, 3);
        chk("stall_done", 32'(n_done), 32'd1);

        // Empty FIFO for four cycles, then data arrives
        clear_stats();
        kick(2);
        for (int i = 0; i < 4; i++) step();
        chk("empty_pops", 32'(n_pops), 32'd0);
        fifo_q.push_back(32'hA);
        fifo_q.push_back(32'hB);
        refresh();
        run_idle(50, "empty");
        chk("empty_total_pops", 32'(n_pops), 32'd2);
        chk_seq("empty", 32'hA, 2);
        chk("empty_done", 32'(n_done), 32'd1);
`ifdef FIFO_READER_STALL_CNT_EN
        chk("empty_stall_cnt", stall_cnt, 32'd4);
`endif

        // Zero-length burst
        clear_stats();
        kick(0);
        run_idle(10, "zero");
        chk("zero_pops", 32'(n_pops), 32'd0);
        chk("zero_done", 32'(n_done), 32'd1);

        // Reset after the first of four words has transferred
        for (int i = 0; i < 4; i++) fifo_q.push_back(32'h30 + 32'(i));
        refresh();
        out_ready = 1'b0;
        clear_stats();
        kick(4);
        step();
        out_ready = 1'b1;
        step();
        chk("abort_delivered", 32'(delivered.size()), 32'd1);
        nrst = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_fifo_pop", 32'(fifo_pop), 32'd0);
        chk("abort_out_data", out_data, 32'd0);
        fifo_q.delete();
        refresh();
        model_reset();
        clear_stats();
        step();
        step();
        nrst = 1'b1;
        step();
        chk("abort_no_done", 32'(n_done), 32'd0);
        fifo_q.push_back(32'h55);
        refresh();
        clear_stats();
        kick(1);
        run_idle(20, "after_abort");
        chk("after_abort_pops", 32'(n_pops), 32'd1);
        chk_seq("after_abort", 32'h55, 1);
        chk("after_abort_done", 32'(n_done), 32'd1);

        // Second start while busy must not reload the length
        for (int i = 0; i < 3; i++) fifo_q.push_back(32'h40 + 32'(i));
        refresh();
        out_ready = 1'b0;
        clear_stats();
        kick(3);
        start = 1'b1;
        burst_len = 16'd7;
        step();
        start = 1'b0;
        out_ready = 1'b1;
        run_idle(100, "restart");
        chk("restart_pops", 32'(n_pops), 32'd3);
        chk_seq("restart", 32'h40, 3);
        chk("restart_done", 32'(n_done), 32'd1);

        // Randomized bursts with random FIFO arrivals and downstream backpressure
        for (int b = 0; b < 20; b++) begin
            len = int'($urandom_range(1, 6));
            rexp.delete();
            pushed = 0;
            clear_stats();
            out_ready = ($urandom % 4) != 0;
            kick(len);
            ok = 1'b0;
            for (int c = 0; c < 300; c++) begin
                if (pushed < len && ($urandom % 2) == 1) begin
                    fifo_q.push_back($urandom);
                    rexp.push_back(fifo_q[$]);
                    pushed++;
                end
                refresh();
                out_ready = ($urandom % 4) != 0;
                if (m_busy && ($urandom % 8) == 0) begin
                    start = 1'b1;
                    burst_len = 16'($urandom_range(0, 9));
                end
                step();
                start = 1'b0;
                if (!m_busy && !m_done) begin
                    ok = 1'b1;
                    break;
                end
            end
            chk("rand_timeout", 32'(ok), 32'd1);
            chk("rand_count", 32'(delivered.size()), 32'(len));
            for (int i = 0; i < rexp.size() && i < delivered.size(); i++)
                chk("rand_word", delivered[i], rexp[i]);
            chk("rand_done", 32'(n_done), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
